// File: rtl/nibble_packer_32.sv
// Nibble-to-word packer: gathers up to eight 4-bit nibbles into a 32-bit word,
// nibble k at bits [4k+3:4k], with valid/ready on both sides and early flush via in_last.
module nibble_packer_32 #(
    parameter int NUM_NIB   = 8,
    parameter bit ZERO_FILL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_nib,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [3:0]  out_count
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  idx;
    logic [31:0] word;
    logic [3:0]  cnt;
    logic        accept;
    logic        word_end;

    assign accept   = in_valid & in_ready;
    assign word_end = (idx == 3'(NUM_NIB - 1)) | in_last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the default assignment at the top keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (accept && word_end) state_nxt = HOLD;
            HOLD: if (out_ready)          state_nxt = FILL;
            default:                      state_nxt = FILL;
        endcase
    end

    // Outputs decode from state only; rst gates in_ready so nothing is taken during reset.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_word  = 32'h0;
        out_count = 4'h0;
        case (state)
            FILL: in_ready = ~rst;
            HOLD: begin
                out_valid = 1'b1;
                out_word  = word;
                out_count = cnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= 3'd0;
            word <= 32'h0;
            cnt  <= 4'd0;
        end else if (accept) begin
            word[4*idx +: 4] <= in_nib;
            cnt              <= cnt + 4'd1;
            idx              <= word_end ? 3'd0 : idx + 3'd1;
        end else if (state == HOLD && out_ready) begin
            cnt <= 4'd0;
            if (ZERO_FILL) word <= 32'h0;
        end
    end

endmodule

// File: doc/nibble_packer_32.md
Name: nibble_packer_32

Overview:
Assembles a 32-bit word from a stream of 4-bit nibbles. It is the write-side counterpart of the nibble-select path: nibble k of the stream lands in bits [4k+3:4k], so a downstream 3-bit selector with s=k returns it unchanged. Input and output each use a valid/ready handshake. A partial word can be flushed early with in_last.

Parameters:
NUM_NIB, 8, nibbles per full word; fixed at 8 for this block (out_word is 32 bits); other values unsupported.
ZERO_FILL, 1, when 1, nibble slots not written before a flush read 0; when 0, they hold stale data.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_nib is valid this cycle
in_ready  output  1  packer accepts a nibble this cycle
in_nib  input  4  nibble data
in_last  input  1  qualifies in_valid; the nibble is the final one of the word (early flush)
out_valid  output  1  out_word and out_count are valid
out_ready  input  1  consumer takes the word this cycle
out_word  output  32  packed word; nibble k at bits [4k+3:4k]
out_count  output  4  number of nibbles written into out_word, range 1..8

Behaviour:
- Reset (synchronous, rst=1 at a clk edge), with rst taking priority over every other input:
  - state = FILL, idx = 0, out_word = 0, out_count = 0, out_valid = 0.
  - in_ready is 0 while rst=1 and 1 on the first cycle after rst is released.
- States: FILL and HOLD. Registers: idx[2:0], word[31:0], cnt[3:0].
- FILL:
  - in_ready = 1, out_valid = 0.
  - Accept occurs when in_valid & in_ready. On accept: word[4*idx +: 4] <= in_nib; cnt <= cnt+1.
  - If idx==7 or in_last=1: go to HOLD; idx <= 0.
  - Otherwise idx <= idx+1.
- HOLD:
  - in_ready = 0, out_valid = 1; out_word = word, out_count = cnt.
  - Both outputs stay stable until the handshake completes.
  - When out_ready=1: go to FILL; cnt <= 0; word <= 0 if ZERO_FILL=1, else word is unchanged.
- Latency: out_valid rises on the cycle after the edge that accepted the final nibble. Minimum period is 9 cycles per full word: 8 accepts plus 1 HOLD cycle.
- No same-cycle pass-through: in HOLD, in_ready is 0 even when out_ready=1. The first nibble of the next word is accepted no earlier than the cycle after the output handshake.
- idx wrap-around: idx never exceeds 7. Accepting the nibble at idx 7 always ends the word, whatever in_last is.
- in_last is ignored when in_valid=0. in_last=1 together with idx 7 gives the same result as a normal full word (out_count=8).
- in_last on the first nibble gives out_count=1, with out_word[3:0]=in_nib and the upper bits 0 (ZERO_FILL=1).
- Data is ignored when in_valid=0; word, idx and cnt hold.
- Backpressure: HOLD may last any number of cycles. out_word and out_count must not change while out_valid=1 and out_ready=0.
- Reset mid-word or in HOLD: the partial or pending word is discarded and is never presented. The next word starts at idx 0.
- out_ready while out_valid=0 has no effect.
- Outputs are registered, or decoded from state only; there is no combinational path from in_* to out_* or from out_ready to in_ready.

Test Plan:
- Full word: rst, then 8 back-to-back accepts of nibbles 1,2,...,8 with out_ready=1 -> out_valid for exactly 1 cycle, out_word=0x87654321, out_count=8; in_ready=0 that cycle, then 1 again.
- Early flush: nibbles A,B,C with in_last on C, ZERO_FILL=1 -> out_word=0x00000CBA, out_count=3. Then nibble 5 with in_last -> out_word=0x00000005, out_count=1 (no residue from the previous word).
- Backpressure: full word 0xDEADBEEF (nibbles F,E,E,B,D,A,E,D) with out_ready=0 for 5 cycles -> out_valid held for 5+ cycles, word stable, in_ready=0 and extra in_valid pulses ignored; out_ready=1 -> one transfer, then in_ready=1 on the next cycle.
- Input gaps: in_valid toggled 1,0,0,1,... with random in_nib during the gaps -> out_word contains only the accepted nibbles, in order.
- Reset mid-operation: accept 5 nibbles, assert rst for 1 cycle, then send 8 nibbles 0..7 -> out_word=0x76543210, out_count=8, and no output from the aborted word. Separately, rst during HOLD -> out_valid=0 on the next cycle.
- Selector round-trip: for a random 32-bit value V, send its nibbles in order -> for each s in 0..7, out_word[4s+3:4s] equals V nibble s (checked through the existing 8-to-1 nibble selector).
